// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - PWM period and 8-bit duty decoder with stuck-input timeout
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic             duty_valid,
  output logic             busy,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             tmo_hit;
  logic             fell_q, fell_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] div_p_q, div_p_d;
  logic [CNT_W:0]   rem_q, rem_d, rem_sh;
  logic [7:0]       quo_q, quo_d;
  logic             quo_bit;
  logic [2:0]       step_q, step_d;
  logic             sat_q, sat_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hi_sel;
  logic [7:0]       duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             ovr_q, ovr_d;

  // Two-flop synchronizer followed by one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  // Period counter saturates at TIMEOUT; the stuck strobe fires only on arrival there
  assign cnt_inc = (cnt_q == TMO_VAL) ? cnt_q : cnt_q + CNT_ONE;
  assign tmo_hit = (cnt_q != TMO_VAL) && (cnt_inc == TMO_VAL);

  // Measurement FSM, restoring divider and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fell_q   <= 1'b0;
      high_q   <= '0;
      div_p_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      step_q   <= '0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fell_q   <= fell_d;
      high_q   <= high_d;
      div_p_q  <= div_p_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      step_q   <= step_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next state: one divider step per cycle, edge handling, then timeout (a rise beats it)
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    fell_d   = fell_q;
    high_d   = high_q;
    div_p_d  = div_p_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    step_d   = step_q;
    sat_d    = sat_q;
    busy_d   = busy_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    ovr_d    = ovr_q;
    rem_sh   = rem_q << 1;
    quo_bit  = (rem_sh >= {1'b0, div_p_q});
    // Without a fall in the period the high time equals the period, which saturates
    hi_sel   = fell_q ? high_q : cnt_q;

    if (busy_q) begin
      rem_d  = quo_bit ? (rem_sh - {1'b0, div_p_q}) : rem_sh;
      quo_d  = {quo_q[6:0], quo_bit};
      step_d = step_q + 3'd1;
      if (step_q == 3'd7) begin
        busy_d   = 1'b0;
        duty_d   = sat_q ? 8'hFF : {quo_q[6:0], quo_bit};
        period_d = div_p_q;
        valid_d  = 1'b1;
        tmo_d    = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
          fell_d  = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          cnt_d  = CNT_ONE;
          fell_d = 1'b0;
          if (busy_q) begin
            ovr_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            step_d  = '0;
            quo_d   = '0;
            div_p_d = cnt_q;
            sat_d   = (hi_sel >= cnt_q);
            rem_d   = (hi_sel >= cnt_q) ? '0 : {1'b0, hi_sel};
          end
        end else if (fall && !fell_q) begin
          fell_d = 1'b1;
          high_d = cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit && !rise) begin
      state_d  = IDLE;
      duty_d   = s2_q ? 8'hFF : 8'h00;
      period_d = '0;
      valid_d  = 1'b1;
      tmo_d    = 1'b1;
    end
  end

  assign duty       = duty_q;
  assign period     = period_q;
  assign duty_valid = valid_q;
  assign busy       = busy_q;
  assign timeout    = tmo_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - self-checking bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

  localparam int CNT_W = 16;
  localparam int TMO   = 300;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [7:0]       duty;
  logic [CNT_W-1:0] period;
  logic             duty_valid;
  logic             busy;
  logic             timeout;
  logic             overrun;

  always #5 clk = ~clk;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty(duty), .period(period),
    .duty_valid(duty_valid), .busy(busy), .timeout(timeout), .overrun(overrun)
  );

  typedef struct { int edge_n; int duty; int per; int tmo; } strobe_t;
  typedef struct { int per; int hi; int nper; int exp_duty; int exp_per; } vec_t;

  strobe_t obs_q[$];
  strobe_t exp_q[$];
  logic    wave[$];
  int      cyc   = 0;
  int      n_cmp = 0;
  int      n_bad = 0;

  // Reference model state, kept in terms of edge indices of the input waveform
  int m_last_rst = -1, m_armed = 0, m_lr = 0, m_ff = -1, m_origin = 0;
  int m_pend = 0, m_start = 0, m_duty = 0, m_per = 0, m_tmo = 0, m_ovr = 0;

  // Input level as seen by the synchronizer; the flops are cleared by reset
  function automatic int wv(input int m);
    if (m < 0 || m <= m_last_rst || m >= wave.size()) return 0;
    return wave[m] ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_rec(input string name, input strobe_t g, input strobe_t w);
    n_cmp++;
    if (g.edge_n != w.edge_n || g.duty != w.duty || g.per != w.per || g.tmo != w.tmo) begin
      n_bad++;
      $display("FAIL %s strobe: got edge=%0d duty=%0d period=%0d timeout=%0d, want edge=%0d duty=%0d period=%0d timeout=%0d",
               name, g.edge_n, g.duty, g.per, g.tmo, w.edge_n, w.duty, w.per, w.tmo);
    end
  endtask

  // A measurement is the interval between successive rises; a strobe follows 8 edges later
  task automatic model_edge(input int n, input logic r);
    int p, h;
    bit busy_b, rise_b, fall_b;
    strobe_t s;
    if (r) begin
      m_last_rst = n; m_armed = 0; m_pend = 0; m_origin = n;
      m_tmo = 0; m_ovr = 0; m_ff = -1;
      return;
    end
    rise_b = (wv(n-2) == 1) && (wv(n-3) == 0);
    fall_b = (wv(n-2) == 0) && (wv(n-3) == 1);
    busy_b = (m_pend != 0);
    if (m_pend != 0 && n == m_start + 8) begin
      s.edge_n = n; s.duty = m_duty; s.per = m_per; s.tmo = 0;
      exp_q.push_back(s);
      m_pend = 0; m_tmo = 0;
    end
    if (rise_b) begin
      if (m_armed != 0 && busy_b) begin
        m_ovr = 1;
      end else if (m_armed != 0) begin
        p = n - m_lr;
        h = (m_ff >= 0) ? (m_ff - m_lr) : p;
        m_duty = (h >= p) ? 255 : (h * 256) / p;
        m_per = p; m_pend = 1; m_start = n;
      end
      m_armed = 1; m_lr = n; m_ff = -1; m_origin = n - 1;
    end else if (n - m_origin == TMO) begin
      s.edge_n = n; s.duty = (wv(n-2) == 1) ? 255 : 0; s.per = 0; s.tmo = 1;
      exp_q.push_back(s);
      m_tmo = 1; m_armed = 0;
    end else if (fall_b && m_armed != 0 && m_ff < 0) begin
      m_ff = n;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, observe outputs on the next falling edge
  task automatic tick(input logic p, input logic r);
    strobe_t s;
    pwm_in = p;
    rst    = r;
    wave.push_back(p);
    model_edge(cyc, r);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (duty_valid) begin
      s.edge_n = cyc - 1; s.duty = int'(duty); s.per = int'(period); s.tmo = int'(timeout);
      obs_q.push_back(s);
    end
  endtask

  task automatic hold(input logic p, input int n);
    for (int i = 0; i < n; i++) tick(p, 1'b0);
  endtask

  task automatic run_pwm(input int per, input int hi, input int n, input int glitch);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < per; c++)
        tick((c < hi && c != glitch) ? 1'b1 : 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string name);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk({name, "_reset_outs"}, int'({duty, period, duty_valid, busy, timeout, overrun}), 0);
  endtask

  function automatic strobe_t last_obs();
    strobe_t s;
    s.edge_n = -1; s.duty = -1; s.per = -1; s.tmo = -1;
    if (obs_q.size() > 0) s = obs_q[obs_q.size()-1];
    return s;
  endfunction

  task automatic checkpoint(input string name);
    strobe_t g, w;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        g = obs_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL %s extra strobe: got edge=%0d duty=%0d period=%0d, want none", name, g.edge_n, g.duty, g.per);
      end else if (obs_q.size() == 0) begin
        w = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL %s missing strobe: got none, want edge=%0d duty=%0d period=%0d", name, w.edge_n, w.duty, w.per);
      end else begin
        g = obs_q.pop_front();
        w = exp_q.pop_front();
        chk_rec(name, g, w);
      end
    end
    chk({name, "_overrun"}, int'(overrun), m_ovr);
    chk({name, "_timeout"}, int'(timeout), m_tmo);
  endtask

  initial begin
    vec_t    vecs[6];
    strobe_t s;
    int      base, k, cnt, per, hi, np, gl;

    rst    = 1'b1;
    pwm_in = 1'b0;
    vecs[0] = '{100,  25, 5,  64, 100};
    vecs[1] = '{200, 100, 3, 128, 200};
    vecs[2] = '{200,   1, 3,   1, 200};
    vecs[3] = '{200, 199, 3, 254, 200};
    vecs[4] = '{100,  75, 3, 192, 100};
    vecs[5] = '{100,  50, 3, 128, 100};
    @(negedge clk);

    // Table-driven steady PWM
    for (int v = 0; v < 6; v++) begin
      do_reset("vec");
      run_pwm(vecs[v].per, vecs[v].hi, vecs[v].nper, -1);
      hold(1'b0, 12);
      chk($sformatf("vec%0d_count", v), obs_q.size(), vecs[v].nper - 1);
      for (int i = 0; i < obs_q.size(); i++) begin
        chk($sformatf("vec%0d_duty%0d", v, i), obs_q[i].duty, vecs[v].exp_duty);
        chk($sformatf("vec%0d_period%0d", v, i), obs_q[i].per, vecs[v].exp_per);
      end
      checkpoint($sformatf("vec%0d", v));
    end

    // Stuck low, stuck high, then recovery
    do_reset("stuck");
    run_pwm(100, 50, 3, -1);
    hold(1'b0, TMO + 10);
    s = last_obs();
    chk("stuck_low_duty", s.duty, 0);
    chk("stuck_low_period", s.per, 0);
    chk("stuck_low_tmo", s.tmo, 1);
    hold(1'b1, TMO + 10);
    s = last_obs();
    chk("stuck_high_duty", s.duty, 255);
    chk("stuck_high_tmo", s.tmo, 1);
    base = obs_q.size();
    hold(1'b0, 5);
    run_pwm(100, 50, 3, -1);
    hold(1'b0, 12);
    chk("resume_count", obs_q.size() - base, 2);
    s = last_obs();
    chk("resume_duty", s.duty, 128);
    chk("resume_tmo", s.tmo, 0);
    checkpoint("stuck");

    // Overrun is sticky, later valid measurements still decode
    do_reset("ovr");
    run_pwm(6, 3, 6, -1);
    chk("ovr_set", int'(overrun), 1);
    run_pwm(100, 75, 3, -1);
    hold(1'b0, 12);
    chk("ovr_sticky", int'(overrun), 1);
    s = last_obs();
    chk("ovr_after_duty", s.duty, 192);
    checkpoint("ovr");

    // Reset asserted in the middle of a division
    do_reset("mid");
    run_pwm(100, 50, 2, -1);
    k = cyc;
    hold(1'b1, 5);
    tick(1'b1, 1'b1);
    chk("mid_duty", int'(duty), 0);
    chk("mid_period", int'(period), 0);
    chk("mid_valid", int'(duty_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_timeout", int'(timeout), 0);
    chk("mid_overrun", int'(overrun), 0);
    hold(1'b1, 44);
    hold(1'b0, 50);
    run_pwm(100, 50, 2, -1);
    hold(1'b0, 12);
    cnt = 0;
    foreach (obs_q[i]) if (obs_q[i].edge_n >= k + 3 && obs_q[i].edge_n <= k + 101) cnt++;
    chk("mid_no_strobe", cnt, 0);
    checkpoint("mid");

    // One-cycle low glitch inside the high phase
    do_reset("glitch");
    run_pwm(100, 60, 2, -1);
    run_pwm(100, 60, 1, 20);
    run_pwm(100, 60, 2, -1);
    hold(1'b0, 12);
    s = last_obs();
    chk("glitch_clean_duty", s.duty, 153);
    checkpoint("glitch");

    // Randomized segments against the reference model
    do_reset("rand");
    for (int seg = 0; seg < 8; seg++) begin
      per = $urandom_range(4, 250);
      hi  = $urandom_range(1, per - 1);
      np  = $urandom_range(2, 4);
      gl  = ($urandom_range(0, 3) == 0 && hi > 2) ? $urandom_range(1, hi - 2) : -1;
      run_pwm(per, hi, np, gl);
    end
    hold(1'b0, 12);
    checkpoint("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Measures a PWM waveform on one input pin and reports its period and 8-bit duty cycle. It is the receiving end of the motor-control PWM output. The motor controller drives the PWM, and this block decodes it back into a duty code. It is used for closed-loop feedback and for checking the controller in the bench. A synchronizer, an edge-timed measurement FSM and an 8-step sequential divider produce one duty sample per PWM period.

## Interface
Parameters:
- CNT_W, 16: width of the period and high-time counters.
- TIMEOUT, 50000: number of clk cycles with no rising edge before the input is declared stuck. Must be ≥ 16 and < 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pwm_in  in  1  PWM input, asynchronous to clk.
- duty  out  8  last decoded duty, 0 = 0 %, 255 = 100 %.
- period  out  CNT_W  last measured period in clk cycles; 0 after a timeout.
- duty_valid  out  1  one-cycle strobe; duty and period were updated this cycle.
- busy  out  1  divider running.
- timeout  out  1  input stuck; level signal.
- overrun  out  1  sticky; a sample was dropped.

## Operation
- **Input conditioning:** pwm_in passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- **FSM states:** IDLE, MEASURE.
  - IDLE: wait for rise, then go to MEASURE. No sample is produced on the first rise after reset or after a timeout.
  - MEASURE:
    - The period counter counts clk cycles since the last rise.
    - The high counter is frozen on the first fall after the rise. Later falls in the same period are ignored.
    - On rise, latch P = exact number of cycles between the two rises and H = cycles from the rise to the first fall.
    - Then restart both counters and start the divider.
- **Divider:**
  - Initialize remainder r = H.
  - Run 8 iterations, one per cycle, MSB first: r = r<<1; if r ≥ P then set the quotient bit and r = r − P.
  - Result: duty = floor(H·256/P).
  - If H ≥ P (only possible through a glitch), duty saturates to 255.
  - Internal width is CNT_W+1 so r<<1 does not overflow.
- **Overrun:** a rise while busy=1 discards that sample.
  - The counters still restart.
  - overrun is set and stays set until rst.
  - Any PWM period of 9 cycles or more never overruns.
- **Timeout:** triggers when the period counter reaches TIMEOUT, in IDLE or MEASURE.
  - duty = 255 if s2=1, else 0.
  - period = 0.
  - duty_valid pulses once, timeout = 1, FSM goes to IDLE.
  - No further timeout strobes occur while stuck.
  - timeout clears on the next duty_valid produced by a divider result.
- **Counters:** saturate at TIMEOUT and never wrap.
- **Reset values:** rst at any time, including mid-divide, returns:
  - FSM to IDLE and all counters to 0;
  - duty = 0, period = 0, duty_valid = 0, busy = 0, timeout = 0, overrun = 0.
  - An in-flight division is abandoned, with no strobe.

## Timing
- Let edge k be the first clk edge that samples pwm_in high for a second or later rise.
  - s2 goes high at k+1.
  - rise is true during the cycle k+1→k+2.
  - P and H are latched at k+2.
  - busy is high from k+2 to k+10.
  - duty, period and duty_valid register at k+10.
  - duty_valid is high for exactly one cycle.
- A fall delays the high-time measurement by the same 2-cycle latency, so H equals the true high time.
- The timeout strobe is registered on the edge where the counter reaches TIMEOUT.
- If a timeout and a rise occur in the same cycle, the rise wins: it is a measurement and no timeout is reported.
- duty and period hold their values between strobes.

## Test plan
- **Basic duty:** period 100, high 25, 5 periods.
  - Expect 4 strobes, each duty=64, period=100.
  - Each strobe 10 edges after the pwm_in rise; timeout=0.
- **Sweep:** period 200 with high = 100, 1, 199.
  - Expect duty = 128, 1, 254 respectively.
- **Stuck levels:** hold pwm_in low for TIMEOUT+10 cycles after running PWM.
  - Expect one strobe with duty=0, period=0, timeout=1.
  - Repeat holding high: expect duty=255.
  - Then resume a 100/50 PWM: the first rise gives no strobe, the second gives duty=128 and timeout=0.
- **Overrun:** period 6, high 3.
  - Expect overrun=1, and it stays 1.
  - Then 100/75 gives valid duty=192 strobes.
- **Reset mid-divide:** assert rst at k+5.
  - Expect no strobe and all outputs 0 on the next cycle.
  - After release, the first rise produces no sample.
- **Glitch:** a 1-cycle low pulse inside the high phase of a 100/60 PWM.
  - Expect H frozen at the first fall.
  - duty reflects the glitch position, and the next clean period gives duty=153.
